// File: rtl/configs_loader.sv
// Configuration-word store for a LUT tile: loads NUM_WORDS words over a valid/ready
// stream into flat config registers, with done flag, XOR checksum and registered readback.
module configs_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 14,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic                        io_in_valid,
  output logic                        io_in_ready,
  input  logic [WORD_W-1:0]           io_d_in,
  input  logic [ADDR_W-1:0]           io_rd_addr,
  output logic [WORD_W-1:0]           io_rd_data,
  output logic [WORD_W*NUM_WORDS-1:0] io_configs_out,
  output logic                        io_busy,
  output logic                        io_done,
  output logic [WORD_W-1:0]           io_checksum
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WORD_W-1:0] checksum_q, checksum_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [WORD_W-1:0] words_q [NUM_WORDS];
  logic              accept;
  logic              last_word;

  // Start wins over a same-cycle handshake, so the offered word is refused.
  assign io_in_ready = (state_q == StLoad) && !io_start && !reset;
  assign accept      = io_in_valid && io_in_ready;
  assign last_word   = (ptr_q == ADDR_W'(NUM_WORDS - 1));

  assign io_busy     = (state_q == StLoad);
  assign io_done     = (state_q == StDone);
  assign io_checksum = checksum_q;
  assign io_rd_data  = rd_data_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    checksum_d = checksum_q;
    if (io_start) begin
      state_d    = StLoad;
      ptr_d      = '0;
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q ^ io_d_in;
      ptr_d      = ptr_q + ADDR_W'(1);
      if (last_word) begin
        state_d = StDone;
      end
    end
  end

  // Decoded read mux; addresses past the last word fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (io_rd_addr == ADDR_W'(k)) begin
        rd_data_d = words_q[k];
      end
    end
  end

  always_comb begin
    io_configs_out = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      io_configs_out[k*WORD_W +: WORD_W] = words_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      checksum_q <= '0;
      rd_data_q  <= '0;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        words_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      checksum_q <= checksum_d;
      rd_data_q  <= rd_data_d;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (accept && (ptr_q == ADDR_W'(k))) begin
          words_q[k] <= io_d_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_configs_loader.sv
// Self-checking bench for configs_loader: table-driven full load plus hand-written
// sequences, with a reference model feeding an expected-results queue.
module tb_configs_loader;

  localparam int W  = 32;
  localparam int N  = 14;
  localparam int A  = 4;
  localparam int CW = W * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_d_in;
  logic [A-1:0]  io_rd_addr;
  logic [W-1:0]  io_rd_data;
  logic [CW-1:0] io_configs_out;
  logic          io_busy;
  logic          io_done;
  logic [W-1:0]  io_checksum;

  always #5 clk = ~clk;

  configs_loader #(.WORD_W(W), .NUM_WORDS(N), .ADDR_W(A)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_d_in       (io_d_in),
    .io_rd_addr    (io_rd_addr),
    .io_rd_data    (io_rd_data),
    .io_configs_out(io_configs_out),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_checksum   (io_checksum)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 load, 2 done.
  int           m_state = 0;
  int           m_ptr   = 0;
  logic [W-1:0] m_chk   = '0;
  logic [W-1:0] m_words [N];

  typedef struct {
    logic [W-1:0]  rd;
    logic [W-1:0]  chk;
    logic          busy;
    logic          done;
    logic [CW-1:0] cfg;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic         rst;
    logic         st;
    logic         vld;
    logic [W-1:0] d;
    logic [A-1:0] addr;
    logic         busy;
    logic         done;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_model();
    logic [CW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_words[k];
    return r;
  endfunction

  task automatic cycle(input logic rst, input logic st, input logic vld,
                       input logic [W-1:0] d, input logic [A-1:0] addr);
    exp_t e;
    logic exp_rdy;
    logic acc;
    reset       = rst;
    io_start    = st;
    io_in_valid = vld;
    io_d_in     = d;
    io_rd_addr  = addr;
    #1;
    exp_rdy = (m_state == 1) && !st && !rst;
    check("in_ready", CW'(io_in_ready), CW'(exp_rdy));
    acc  = vld && exp_rdy;
    e.rd = (int'(addr) < N) ? m_words[addr] : '0;
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_chk   = '0;
      for (int k = 0; k < N; k++) m_words[k] = '0;
      e.rd = '0;
    end else if (st) begin
      m_state = 1;
      m_ptr   = 0;
      m_chk   = '0;
    end else if (acc) begin
      m_words[m_ptr] = d;
      m_chk          = m_chk ^ d;
      if (m_ptr == N - 1) m_state = 2;
      m_ptr++;
    end
    e.chk  = m_chk;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    e.cfg  = pack_model();
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("rd_data", CW'(io_rd_data), CW'(e.rd));
    check("checksum", CW'(io_checksum), CW'(e.chk));
    check("busy", CW'(io_busy), CW'(e.busy));
    check("done", CW'(io_done), CW'(e.done));
    check("configs", io_configs_out, e.cfg);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] cfg_full;
    logic [CW-1:0] cfg_rs;
    int n;
    logic v;

    for (int k = 0; k < N; k++) begin
      cfg_full[k*W +: W] = W'(32'h1000_0000 + k);
      cfg_rs[k*W +: W]   = (k < 5) ? W'(32'h5555_0000 + k) : W'(32'hAAAA_0000 + k);
    end

    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0};
    for (int i = 1; i <= 14; i++) begin
      tbl[i] = '{1'b0, 1'b0, 1'b1, W'(32'h1000_0000 + i - 1), 4'd0, (i < 14), (i == 14)};
    end
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'd13, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0, 4'd15, 1'b0, 1'b1};

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), $urandom, 4'($urandom));
    end
    check("rst_cfg", io_configs_out, '0);
    check("rst_done", CW'(io_done), '0);

    // Full load from the vector table.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].st, tbl[i].vld, tbl[i].d, tbl[i].addr);
      check("tbl_busy", CW'(io_busy), CW'(tbl[i].busy));
      check("tbl_done", CW'(io_done), CW'(tbl[i].done));
      if (i == 15) check("rd13", CW'(io_rd_data), CW'(32'h1000_000D));
      if (i == 16) check("rd15", CW'(io_rd_data), '0);
    end
    check("full_cfg", io_configs_out, cfg_full);
    check("full_chk", CW'(io_checksum), CW'(32'h0000_0001));

    // Same data with random valid gaps.
    cycle(1'b0, 1'b1, 1'b0, '0, 4'd0);
    n = 0;
    for (int c = 0; c < 200 && n < N; c++) begin
      v = 1'($urandom_range(0, 1));
      cycle(1'b0, 1'b0, v, W'(32'h1000_0000 + n), 4'(c));
      if (v) n++;
    end
    check("bp_count", CW'(n), CW'(N));
    check("bp_cfg", io_configs_out, cfg_full);
    check("bp_chk", CW'(io_checksum), CW'(32'h0000_0001));
    check("bp_done", CW'(io_done), CW'(1'b1));

    // Restart mid-session; start cycle carries a word that must be refused.
    cycle(1'b0, 1'b1, 1'b0, '0, 4'd0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, W'(32'hAAAA_0000 + i), 4'd0);
    cycle(1'b0, 1'b1, 1'b0, '0, 4'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, W'(32'h5555_0000 + i), 4'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'd5);
    check("rs_cfg", io_configs_out, cfg_rs);
    check("rs_chk", CW'(io_checksum), '0);
    check("rs_busy", CW'(io_busy), CW'(1'b1));
    check("rs_rd5", CW'(io_rd_data), CW'(32'hAAAA_0005));

    // Reset after 7 accepts, then valid words without a start.
    cycle(1'b0, 1'b1, 1'b0, '0, 4'd0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, W'(32'h7777_0000 + i), 4'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, 4'd0);
    check("mr_cfg", io_configs_out, '0);
    check("mr_done", CW'(io_done), '0);
    check("mr_busy", CW'(io_busy), '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, W'(32'hBEEF_0000 + i), 4'd0);
    check("mr_idle_cfg", io_configs_out, '0);
    check("mr_idle_chk", CW'(io_checksum), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
